// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte responder.
`timescale 1ns / 1ps

package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RX     = 2'd1,
        ST_ACK    = 2'd2,
        ST_IGNORE = 2'd3
    } state_e;

    localparam logic I2C_ACK       = 1'b0;
    localparam logic I2C_NACK      = 1'b1;
    localparam int   BITS_PER_BYTE = 8;

    // An address byte is ours only when it carries our address with the write bit.
    function automatic logic addr_match(input logic [7:0] b, input logic [6:0] addr);
        return (b[7:1] == addr) && (b[0] == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the SCL/SDA pads and turns their edges into registered one-clk events.
`timescale 1ns / 1ps

module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_now;
    logic                   sda_now;
    logic                   scl_prev;

    assign scl_now = scl_sync[SYNC_STAGES-1];
    assign sda_now = sda_sync[SYNC_STAGES-1];

    // Reset to the idle bus level so releasing reset never fakes an edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_prev  <= 1'b1;
            sda       <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_prev  <= scl_now;
            sda       <= sda_now;
            scl_rise  <= scl_now & ~scl_prev;
            scl_fall  <= ~scl_now & scl_prev;
            start_det <= scl_now & scl_prev & ~sda_now & sda;
            stop_det  <= scl_now & scl_prev & sda_now & ~sda;
        end
    end

endmodule

// File: rtl/i2c_byte_responder.sv
// Write-only I2C target: receives bytes, ACKs/NACKs open-drain, hands bytes to the core.
// Define I2C_ADDR_MATCH_EN to treat the first byte after START as a 7-bit address.
`timescale 1ns / 1ps

module i2c_byte_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h13,
    parameter int         SYNC_STAGES = 2,
    parameter int         HOLD_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_addr_hit,
    output logic       rx_start,
    output logic       rx_stop,
    output logic       busy
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    if (SYNC_STAGES < 2 || HOLD_CYC < 1) begin : g_bad_params
        $error("SYNC_STAGES must be >= 2 and HOLD_CYC >= 1");
    end
    if (ADDR[6:3] == 4'b0000 || ADDR[6:3] == 4'b1111) begin : g_reserved_addr
        $error("ADDR lies in an I2C reserved address range");
    end

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_e                     state;
    logic [2:0]                 bit_cnt;
    logic [BITS_PER_BYTE-2:0]   shift;
    logic [HW-1:0]              hold_cnt;
    logic                       ack_bit;
    logic                       ack_phase;   // 0: drive after 8th fall, 1: release after 9th
    logic [7:0]                 byte_now;
    logic                       ack_now;
`ifdef I2C_ADDR_MATCH_EN
    logic                       addr_phase;
`endif

    assign byte_now = {shift, sda};

    always_comb begin
        // NOTE: default first so every path assigns ack_now and no latch is inferred.
        ack_now = I2C_NACK;
`ifdef I2C_ADDR_MATCH_EN
        if (addr_phase) begin
            if (addr_match(byte_now, ADDR)) ack_now = I2C_ACK;
        end else if (rx_ready) begin
            ack_now = I2C_ACK;
        end
`else
        if (rx_ready) ack_now = I2C_ACK;
`endif
    end

`ifndef I2C_ADDR_MATCH_EN
    assign rx_addr_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            hold_cnt  <= '0;
            ack_bit   <= I2C_NACK;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_start  <= 1'b0;
            rx_stop   <= 1'b0;
            busy      <= 1'b0;
`ifdef I2C_ADDR_MATCH_EN
            rx_addr_hit <= 1'b0;
            addr_phase  <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            rx_start <= 1'b0;
            rx_stop  <= 1'b0;
`ifdef I2C_ADDR_MATCH_EN
            rx_addr_hit <= 1'b0;
`endif
            if (stop_det) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                sda_oe   <= 1'b0;
                rx_stop  <= 1'b1;
                bit_cnt  <= '0;
                hold_cnt <= '0;
            end else if (start_det) begin
                state    <= ST_RX;
                busy     <= 1'b1;
                sda_oe   <= 1'b0;
                rx_start <= 1'b1;
                bit_cnt  <= '0;
                hold_cnt <= '0;
`ifdef I2C_ADDR_MATCH_EN
                addr_phase <= 1'b1;
`endif
            end else begin
                case (state)
                    ST_RX: begin
                        if (scl_rise) begin
                            shift   <= byte_now[BITS_PER_BYTE-2:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
                                ack_bit   <= ack_now;
                                ack_phase <= 1'b0;
                                hold_cnt  <= '0;
                                state     <= ST_ACK;
`ifdef I2C_ADDR_MATCH_EN
                                addr_phase <= 1'b0;
                                if (ack_now == I2C_ACK) begin
                                    if (addr_phase) begin
                                        rx_addr_hit <= 1'b1;
                                    end else begin
                                        rx_data  <= byte_now;
                                        rx_valid <= 1'b1;
                                    end
                                end
`else
                                if (ack_now == I2C_ACK) begin
                                    rx_data  <= byte_now;
                                    rx_valid <= 1'b1;
                                end
`endif
                            end
                        end
                    end
                    // SDA only moves HOLD_CYC clocks after SCL falls to respect hold time.
                    ST_ACK: begin
                        if (scl_fall) begin
                            hold_cnt <= HW'(HOLD_CYC);
                        end else if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - HW'(1);
                            if (hold_cnt == HW'(1)) begin
                                if (!ack_phase) begin
                                    sda_oe    <= (ack_bit == I2C_ACK);
                                    ack_phase <= 1'b1;
                                end else begin
                                    sda_oe  <= 1'b0;
                                    bit_cnt <= '0;
                                    state   <= (ack_bit == I2C_ACK) ? ST_RX : ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_IGNORE: sda_oe <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_byte_responder.sv
// Scoreboard bench: stimulus pushes expected events, a monitor pops them as pulses appear.
`timescale 1ns / 1ps

module tb_i2c_byte_responder;

`ifdef I2C_ADDR_MATCH_EN
    localparam bit ADDR_EN = 1'b1;
`else
    localparam bit ADDR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       rx_ready = 1'b1;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_addr_hit;
    logic       rx_start;
    logic       rx_stop;
    logic       busy;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;   // open-drain wired-AND with pull-up

    always #10 clk = ~clk;            // 50 MHz

    i2c_byte_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .sda_oe      (sda_oe),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_addr_hit (rx_addr_hit),
        .rx_start    (rx_start),
        .rx_stop     (rx_stop),
        .busy        (busy)
    );

    typedef enum int {EV_NONE, EV_START, EV_STOP, EV_VALID, EV_HIT} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    ev_t sb_q[$];
    int  check_cnt = 0;
    int  pass_cnt  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic expect_ev(input ev_kind_e k, input logic [7:0] d);
        if (k != EV_NONE) sb_q.push_back('{kind: k, data: d});
    endtask

    task automatic sb_match(input ev_kind_e k, input logic [7:0] d);
        ev_t e;
        if (sb_q.size() == 0) begin
            check_cnt++;
            $display("FAIL sb_unexpected: got event %0d data %0h, expected none", k, d);
        end else begin
            e = sb_q.pop_front();
            check("sb_kind", 32'(k), 32'(e.kind));
            if (k == EV_VALID) check("sb_rx_data", {24'd0, d}, {24'd0, e.data});
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rx_start    === 1'b1) sb_match(EV_START, 8'h00);
            if (rx_stop     === 1'b1) sb_match(EV_STOP, 8'h00);
            if (rx_valid    === 1'b1) sb_match(EV_VALID, rx_data);
            if (rx_addr_hit === 1'b1) sb_match(EV_HIT, 8'h00);
        end
    end

    // Bit-banged initiator, SCL 1 MHz, SDA changes 200 ns after SCL fall.
    task automatic start_cond();
        #200 sda_m = 1'b1;
        #300 scl_m = 1'b1;
        #250 sda_m = 1'b0;
        #250 scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        #200 sda_m = 1'b0;
        #300 scl_m = 1'b1;
        #250 sda_m = 1'b1;
        #250;
    endtask

    task automatic send_bit(input logic b);
        #200 sda_m = b;
        #300 scl_m = 1'b1;
        #500 scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input ev_kind_e k);
        expect_ev(k, b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        #200 sda_m = 1'b1;
        #300 scl_m = 1'b1;
        #250 check($sformatf("ack_slot_%02h", b), sda_oe, exp_ack);
        #250 scl_m = 1'b0;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_sda_oe", sda_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        rst_n = 1'b1;
        #1000;

        // 1: single byte 0x27 (write bit clear fails address match when enabled)
        expect_ev(EV_START, 8'h00);
        start_cond();
        check("t1_busy", busy, 1'b1);
        send_byte(8'h27, !ADDR_EN, ADDR_EN ? EV_NONE : EV_VALID);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();
        #200;
        check("t1_busy_after_stop", busy, 1'b0);
        check("t1_sda_oe_after_stop", sda_oe, 1'b0);

        // 2: foreign address 0xA0, then 0xA5
        expect_ev(EV_START, 8'h00);
        start_cond();
        send_byte(8'hA0, !ADDR_EN, ADDR_EN ? EV_NONE : EV_VALID);
        send_byte(8'hA5, !ADDR_EN, ADDR_EN ? EV_NONE : EV_VALID);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();

        // 3: 0x26, 0x5A, 0xC3 ACKed, then again with rx_ready low for 0xC3
        expect_ev(EV_START, 8'h00);
        start_cond();
        send_byte(8'h26, 1'b1, ADDR_EN ? EV_HIT : EV_VALID);
        send_byte(8'h5A, 1'b1, EV_VALID);
        send_byte(8'hC3, 1'b1, EV_VALID);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();
        check("t3_rx_data_c3", rx_data, 8'hC3);
        expect_ev(EV_START, 8'h00);
        start_cond();
        send_byte(8'h26, 1'b1, ADDR_EN ? EV_HIT : EV_VALID);
        send_byte(8'h5A, 1'b1, EV_VALID);
        rx_ready = 1'b0;
        send_byte(8'hC3, 1'b0, EV_NONE);
        check("t3_rx_data_held", rx_data, 8'h5A);
        rx_ready = 1'b1;
        expect_ev(EV_STOP, 8'h00);
        stop_cond();

        // 4: START, 4 bits, STOP
        expect_ev(EV_START, 8'h00);
        start_cond();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();
        #200;
        check("t4_sda_oe", sda_oe, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_rx_data", rx_data, 8'h5A);

        // 5: repeated START after 5 bits, then a full byte
        expect_ev(EV_START, 8'h00);
        start_cond();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        expect_ev(EV_START, 8'h00);
        start_cond();
        check("t5_busy", busy, 1'b1);
        send_byte(8'h26, 1'b1, ADDR_EN ? EV_HIT : EV_VALID);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();

        // 6: reset pulse while the responder holds SDA low in the ACK slot
        expect_ev(EV_START, 8'h00);
        start_cond();
        expect_ev(ADDR_EN ? EV_HIT : EV_VALID, 8'h26);
        for (int i = 7; i >= 0; i--) send_bit(i == 5 || i == 2 || i == 1);
        #200 sda_m = 1'b1;
        #300 scl_m = 1'b1;
        #200 check("t6_sda_oe_before_reset", sda_oe, 1'b1);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        check("t6_sda_oe_after_reset", sda_oe, 1'b0);
        check("t6_busy_after_reset", busy, 1'b0);
        check("t6_rx_data_after_reset", rx_data, 8'h00);
        #200;
        expect_ev(EV_START, 8'h00);
        start_cond();
        send_byte(8'h26, 1'b1, ADDR_EN ? EV_HIT : EV_VALID);
        expect_ev(EV_STOP, 8'h00);
        stop_cond();

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
